// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks a {reg, value} table and programs a camera over SCCB
// by issuing register writes to an I2C master, with per-entry retries and delay entries.
module sccb_init_seq #(
    parameter int         NUM_REGS     = 73,
    parameter logic [7:0] SLAVE_ADDR   = 8'h42,
    parameter int         MAX_RETRIES  = 3,
    parameter int         DELAY_CYCLES = 1000000,
    parameter logic [7:0] DELAY_MARKER = 8'hFF,
    parameter bit         AUTO_START   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  tbl_idx,
    input  logic [15:0] tbl_data,
    output logic [2:0]  i2c_address,
    output logic [7:0]  i2c_writedata,
    output logic        i2c_write,
    input  logic        i2c_ready,
    input  logic        i2c_success,
    output logic        busy,
    output logic        ready,
    output logic        error,
    output logic [7:0]  err_idx
);
    localparam int DW = $clog2(DELAY_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, WR_SLV, WR_REG, WR_DATA, WR_CTRL,
        WAIT_BUSY, WAIT_DONE, DELAY, NEXT, DONE, ERROR
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      idx_nx, err_nx;
    logic [3:0]      retry, retry_nx;
    logic [DW-1:0]   dcnt, dcnt_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            tbl_idx <= 8'd0;
            err_idx <= 8'd0;
            retry   <= 4'd0;
            dcnt    <= '0;
        end else begin
            state   <= state_nx;
            tbl_idx <= idx_nx;
            err_idx <= err_nx;
            retry   <= retry_nx;
            dcnt    <= dcnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        idx_nx        = tbl_idx;
        err_nx        = err_idx;
        retry_nx      = retry;
        dcnt_nx       = dcnt;
        i2c_write     = 1'b0;
        i2c_address   = 3'd0;
        i2c_writedata = 8'd0;
        case (state)
            // IDLE is only reachable through reset, so AUTO_START fires once per reset release
            IDLE, DONE, ERROR: begin
                if (start || (state == IDLE && AUTO_START)) begin
                    state_nx = WR_SLV;
                    idx_nx   = 8'd0;
                    err_nx   = 8'd0;
                    retry_nx = 4'd0;
                end
            end
            WR_SLV: begin
                i2c_write     = 1'b1;
                i2c_address   = 3'd1;
                i2c_writedata = SLAVE_ADDR;
                state_nx      = FETCH;
            end
            FETCH: begin
                dcnt_nx  = '0;
                state_nx = (tbl_data[15:8] == DELAY_MARKER) ? DELAY : WR_REG;
            end
            WR_REG: begin
                i2c_write     = 1'b1;
                i2c_address   = 3'd2;
                i2c_writedata = tbl_data[15:8];
                state_nx      = WR_DATA;
            end
            WR_DATA: begin
                i2c_write     = 1'b1;
                i2c_address   = 3'd3;
                i2c_writedata = tbl_data[7:0];
                state_nx      = WR_CTRL;
            end
            WR_CTRL: begin
                i2c_write     = 1'b1;
                i2c_address   = 3'd0;
                i2c_writedata = 8'h01;
                state_nx      = WAIT_BUSY;
            end
            WAIT_BUSY: state_nx = i2c_ready ? WAIT_BUSY : WAIT_DONE;
            WAIT_DONE: begin
                if (i2c_ready) begin
                    if (i2c_success) state_nx = NEXT;
                    else if (retry < 4'(MAX_RETRIES)) begin
                        retry_nx = retry + 4'd1;
                        state_nx = WR_REG;
                    end else begin
                        err_nx   = tbl_idx;
                        state_nx = ERROR;
                    end
                end
            end
            DELAY: begin
                if (dcnt == DW'(DELAY_CYCLES - 1)) state_nx = NEXT;
                else dcnt_nx = dcnt + 1'b1;
            end
            NEXT: begin
                retry_nx = 4'd0;
                if (tbl_idx == 8'(NUM_REGS - 1)) state_nx = DONE;
                else begin
                    idx_nx   = tbl_idx + 8'd1;
                    state_nx = FETCH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy  = !(state inside {IDLE, DONE, ERROR});
    assign ready = (state == DONE);
    assign error = (state == ERROR);
endmodule

// File: tb/tb_sccb_init_seq.sv
// tb_sccb_init_seq: random tables and ack/nack plans against a transaction-level
// model of the expected write stream, including inter-write cycle gaps.
module tb_sccb_init_seq;
    localparam int         NR = 6;
    localparam int         MR = 2;
    localparam int         DC = 5;
    localparam logic [7:0] SA = 8'h5A;
    localparam logic [7:0] DM = 8'hFF;

    logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [15:0] tbl_data = 16'd0;
    logic        i2c_ready = 1'b1, i2c_success = 1'b0;
    logic [7:0]  tbl_idx, i2c_writedata, err_idx;
    logic [2:0]  i2c_address;
    logic        i2c_write, busy, ready, error;

    sccb_init_seq #(
        .NUM_REGS(NR), .SLAVE_ADDR(SA), .MAX_RETRIES(MR),
        .DELAY_CYCLES(DC), .DELAY_MARKER(DM), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
        .i2c_address(i2c_address), .i2c_writedata(i2c_writedata), .i2c_write(i2c_write),
        .i2c_ready(i2c_ready), .i2c_success(i2c_success), .busy(busy), .ready(ready),
        .error(error), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [15:0] tbl [NR];
    int          nacks [NR];
    logic [31:0] expq [$];
    logic [31:0] obsq [$];
    bit          outc [$];
    bit          exp_err;
    logic [7:0]  exp_eidx;
    int anchor = 0, idle_bad = 0, both_bad = 0, mst = 0, lat = 0, bl = 0;
    int tests = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, tbl_idx, err_idx, i2c_address, i2c_writedata, i2c_write, busy, ready, error};
    endfunction

    // ROM, I2C master and write monitor all act on the falling edge
    initial forever begin
        @(negedge clk);
        tbl_data = tbl[int'(tbl_idx) % NR];
        if (!reset_n) begin
            mst = 0;
            i2c_ready = 1'b1;
            i2c_success = 1'b0;
        end else begin
            if (i2c_write) begin
                obsq.push_back({5'd0, i2c_address, i2c_writedata, 16'(cyc - anchor)});
                anchor = cyc;
                if (i2c_address == 3'd0) begin
                    lat = $urandom_range(0, 3);
                    bl  = $urandom_range(2, 5);
                    mst = 1;
                end
            end else if (i2c_address != 3'd0 || i2c_writedata != 8'd0) idle_bad++;
            if (mst == 1) begin
                if (lat == 0) begin
                    i2c_ready = 1'b0;
                    i2c_success = 1'b0;
                    mst = 2;
                end else lat--;
            end else if (mst == 2) begin
                bl--;
                if (bl == 0) begin
                    i2c_success = (outc.size() > 0) ? outc.pop_front() : 1'b1;
                    i2c_ready = 1'b1;
                    anchor = cyc;
                    mst = 0;
                end
            end
        end
        if (ready && error) both_bad++;
    end

    // Expected writes as {addr, data, cycles since previous write or master-ready rise}
    task automatic build();
        int pend;
        expq.delete();
        outc.delete();
        exp_err = 1'b0;
        exp_eidx = 8'd0;
        expq.push_back({5'd0, 3'd1, SA, 16'd1});
        pend = 2;
        for (int i = 0; i < NR && !exp_err; i++) begin
            if (tbl[i][15:8] == DM) begin
                pend += DC + 2;
                continue;
            end
            for (int a = 0; ; a++) begin
                expq.push_back({5'd0, 3'd2, tbl[i][15:8], 16'(pend)});
                expq.push_back({5'd0, 3'd3, tbl[i][7:0], 16'd1});
                expq.push_back({5'd0, 3'd0, 8'h01, 16'd1});
                outc.push_back(a >= nacks[i]);
                if (a >= nacks[i]) begin
                    pend = 3;
                    break;
                end
                if (a == MR) begin
                    exp_err = 1'b1;
                    exp_eidx = 8'(i);
                    break;
                end
                pend = 1;
            end
        end
    endtask

    task automatic rand_table(input bit delays);
        for (int i = 0; i < NR; i++) begin
            tbl[i] = {(delays && $urandom_range(0, 4) == 0) ? DM : 8'($urandom_range(0, 254)),
                      8'($urandom)};
            nacks[i] = ($urandom_range(0, 19) == 0) ? 3 : ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0);
        end
    endtask

    task automatic launch(input bit via_reset);
        if (via_reset) begin
            reset_n = 1'b0;
            repeat (3) @(negedge clk);
            build();
            obsq.delete();
            reset_n = 1'b1;
            anchor = cyc;
        end else begin
            @(negedge clk);
            build();
            obsq.delete();
            start = 1'b1;
            anchor = cyc;
            @(negedge clk);
            start = 1'b0;
            check("restart_flags", {21'd0, ready, error, err_idx, busy}, {21'd0, 2'b00, 8'd0, 1'b1});
        end
    endtask

    task automatic finish_run(input string tag, input bit poke);
        bit seen = 1'b0;
        if (poke) begin
            repeat ($urandom_range(3, 30)) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = ready || error;
        end
        check({tag, "_finished"}, 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        check({tag, "_nwrites"}, 32'(obsq.size()), 32'(expq.size()));
        for (int i = 0; i < obsq.size() && i < expq.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), obsq[i], expq[i]);
        check({tag, "_status"}, {20'd0, ready, error, busy, err_idx},
              {20'd0, !exp_err, exp_err, 1'b0, exp_err ? exp_eidx : 8'd0});
        check({tag, "_idx"}, 32'(tbl_idx), exp_err ? 32'(exp_eidx) : 32'(NR - 1));
    endtask

    initial begin
        int n;
        bit found;
        for (int i = 0; i < NR; i++) begin
            tbl[i] = 16'h1000 + 16'(i);
            nacks[i] = 0;
        end
        @(posedge clk);
        #1 check("reset_outputs", outs(), 32'd0);

        tbl[0] = 16'h1280; tbl[1] = 16'h1180; tbl[2] = 16'h13E5;
        launch(1'b1);
        finish_run("basic", 1'b0);

        rand_table(1'b0);
        foreach (nacks[i]) nacks[i] = 0;
        nacks[1] = 2;
        launch(1'b0);
        finish_run("retry", 1'b0);

        nacks[1] = 3;
        launch(1'b0);
        finish_run("exhaust", 1'b0);

        rand_table(1'b0);
        foreach (nacks[i]) nacks[i] = 0;
        tbl[0] = 16'h1280; tbl[1] = {DM, 8'hF0}; tbl[2] = 16'h1204;
        launch(1'b0);
        finish_run("delay", 1'b1);

        // reset while the master is busy with a transaction
        rand_table(1'b0);
        foreach (nacks[i]) nacks[i] = 0;
        launch(1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = !i2c_ready && busy;
        end
        check("mid_reached", 32'(found), 32'd1);
        @(negedge clk);
        n = obsq.size();
        reset_n = 1'b0;
        #1 check("mid_reset_outputs", outs(), 32'd0);
        repeat (4) @(negedge clk);
        check("mid_reset_quiet", 32'(obsq.size()), 32'(n));
        launch(1'b1);
        finish_run("after_reset", 1'b0);

        for (int r = 0; r < 10; r++) begin
            rand_table(1'b1);
            launch(r % 3 == 0);
            finish_run($sformatf("rnd%0d", r), r % 2 == 1);
        end

        check("idle_bus_zero", 32'(idle_bad), 32'd0);
        check("ready_error_excl", 32'(both_bad), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
